// File: rtl/clock_alarm.sv
// clock_alarm: time-of-day clock (hh:mm:ss, 24h internal) with a prescaler,
// per-field increment/decrement setting, 12/24h display mapping, an alarm
// with ring/acknowledge and a day-rollover pulse.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   select[2:0]    in   0=run, 1=set sec, 2=set min, 3=set hour,
//                       4=set alarm min, 5=set alarm hour, 6/7=run
//   increment      in   level; rising edge steps selected field +1
//   decrement      in   level; rising edge steps selected field -1
//   mode_12h       in   1 = 12-hour display on hour_out
//   alarm_en       in   alarm armed
//   alarm_ack      in   level; clears alarm_ring
//   sec_out[5:0]   out  seconds 0..59
//   min_out[5:0]   out  minutes 0..59
//   hour_out[4:0]  out  displayed hour (0..23, or 1..12 in 12h mode)
//   pm_out         out  internal hour >= 12
//   alarm_min_out  out  alarm minute 0..59
//   alarm_hour_out out  alarm hour 0..23
//   alarm_ring     out  alarm active
//   sec_tick       out  one-cycle pulse per seconds advance
//   day_pulse      out  one-cycle pulse on 23:59:59 -> 00:00:00
module clock_alarm #(
  parameter int TICKS_PER_SEC = 2,
  parameter int ALARM_LEN     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] select,
  input  logic       increment,
  input  logic       decrement,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [4:0] hour_out,
  output logic       pm_out,
  output logic [5:0] alarm_min_out,
  output logic [4:0] alarm_hour_out,
  output logic       alarm_ring,
  output logic       sec_tick,
  output logic       day_pulse
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam int CW = $clog2(ALARM_LEN + 1);
  localparam logic [CW-1:0] RING_LAST = CW'(ALARM_LEN - 1);

  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [4:0]    r_hour;
  logic [5:0]    r_alm_min;
  logic [4:0]    r_alm_hour;
  logic          r_inc_d;
  logic          r_dec_d;
  logic          r_ring;
  logic [CW-1:0] r_ring_cnt;
  logic          r_sec_tick;
  logic          r_day_pulse;

  logic          w_run;
  logic          w_adv;
  logic          w_inc_edge;
  logic          w_dec_edge;
  logic          w_up;
  logic          w_dn;
  logic          w_sec_wrap;
  logic          w_min_wrap;
  logic          w_hour_wrap;
  logic [5:0]    w_sec_nx;
  logic [5:0]    w_min_nx;
  logic [4:0]    w_hour_nx;
  logic          w_day;
  logic          w_match;
  logic [4:0]    w_hour_disp;

  // Wrapping +/-1 step without carry for 0..59 fields.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up)      r = (v == 6'd59) ? 6'd0 : v + 6'd1;
    else if (dn) r = (v == 6'd0) ? 6'd59 : v - 6'd1;
    return r;
  endfunction

  // Wrapping +/-1 step without carry for 0..23 fields.
  function automatic logic [4:0] step24(input logic [4:0] v, input logic up, input logic dn);
    logic [4:0] r;
    r = v;
    if (up)      r = (v == 5'd23) ? 5'd0 : v + 5'd1;
    else if (dn) r = (v == 5'd0) ? 5'd23 : v - 5'd1;
    return r;
  endfunction

  // Time runs for select 0 and 4..7; 1..3 freeze time and prescaler.
  assign w_run = (select == 3'd0) || select[2];
  assign w_adv = w_run && (r_presc == PRESC_MAX);

  // Simultaneous rising edges on both buttons cancel out.
  assign w_inc_edge = increment & ~r_inc_d;
  assign w_dec_edge = decrement & ~r_dec_d;
  assign w_up       = w_inc_edge & ~w_dec_edge;
  assign w_dn       = w_dec_edge & ~w_inc_edge;

  assign w_sec_wrap  = (r_sec == 6'd59);
  assign w_min_wrap  = (r_min == 6'd59);
  assign w_hour_wrap = (r_hour == 5'd23);

  // Time value after a seconds advance, with carries.
  assign w_sec_nx  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
  assign w_min_nx  = w_sec_wrap ? (w_min_wrap ? 6'd0 : r_min + 6'd1) : r_min;
  assign w_hour_nx = (w_sec_wrap && w_min_wrap) ? (w_hour_wrap ? 5'd0 : r_hour + 5'd1) : r_hour;

  assign w_day = w_adv && w_sec_wrap && w_min_wrap && w_hour_wrap;

  // Only a real seconds advance onto hh:mm:00 can match, so manual edits
  // that land on the alarm time never ring.
  assign w_match = w_adv && alarm_en && w_sec_wrap &&
                   (w_min_nx == r_alm_min) && (w_hour_nx == r_alm_hour);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
    end else if (w_adv) begin
      r_presc <= '0;
      r_sec   <= w_sec_nx;
      r_min   <= w_min_nx;
      r_hour  <= w_hour_nx;
    end else if (w_run) begin
      r_presc <= r_presc + 1'b1;
    end else begin
      case (select)
        3'd1:    r_sec  <= step60(r_sec, w_up, w_dn);
        3'd2:    r_min  <= step60(r_min, w_up, w_dn);
        3'd3:    r_hour <= step24(r_hour, w_up, w_dn);
        default: ;
      endcase
      // An edit restarts the current second from zero.
      if (w_up || w_dn) r_presc <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alm_min  <= '0;
      r_alm_hour <= '0;
    end else begin
      if (select == 3'd4) r_alm_min  <= step60(r_alm_min, w_up, w_dn);
      if (select == 3'd5) r_alm_hour <= step24(r_alm_hour, w_up, w_dn);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inc_d     <= 1'b0;
      r_dec_d     <= 1'b0;
      r_sec_tick  <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      r_inc_d     <= increment;
      r_dec_d     <= decrement;
      r_sec_tick  <= w_adv;
      r_day_pulse <= w_day;
    end
  end

  // Ring lasts ALARM_LEN seconds advances counted from the match edge;
  // ack/disarm win over a simultaneous match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ring     <= 1'b0;
      r_ring_cnt <= '0;
    end else if (!alarm_en || alarm_ack) begin
      r_ring     <= 1'b0;
      r_ring_cnt <= '0;
    end else if (w_match) begin
      r_ring     <= 1'b1;
      r_ring_cnt <= '0;
    end else if (r_ring && w_adv) begin
      if (r_ring_cnt == RING_LAST) r_ring <= 1'b0;
      else                         r_ring_cnt <= r_ring_cnt + 1'b1;
    end
  end

  always_comb begin
    w_hour_disp = r_hour;
    if (mode_12h) begin
      if (r_hour == 5'd0)       w_hour_disp = 5'd12;
      else if (r_hour > 5'd12)  w_hour_disp = r_hour - 5'd12;
    end
  end

  assign sec_out        = r_sec;
  assign min_out        = r_min;
  assign hour_out       = w_hour_disp;
  assign pm_out         = (r_hour >= 5'd12);
  assign alarm_min_out  = r_alm_min;
  assign alarm_hour_out = r_alm_hour;
  assign alarm_ring     = r_ring;
  assign sec_tick       = r_sec_tick;
  assign day_pulse      = r_day_pulse;

endmodule

// File: tb/tb_clock_alarm.sv
// Testbench for clock_alarm (TICKS_PER_SEC=2, ALARM_LEN=3).
module tb_clock_alarm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] select;
  logic       increment, decrement, mode_12h, alarm_en, alarm_ack;
  logic [5:0] sec_out, min_out, alarm_min_out;
  logic [4:0] hour_out, alarm_hour_out;
  logic       pm_out, alarm_ring, sec_tick, day_pulse;

  always #5 clk = ~clk;

  clock_alarm #(.TICKS_PER_SEC(2), .ALARM_LEN(3)) dut (
    .clk(clk), .reset(reset), .select(select),
    .increment(increment), .decrement(decrement),
    .mode_12h(mode_12h), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .sec_out(sec_out), .min_out(min_out), .hour_out(hour_out), .pm_out(pm_out),
    .alarm_min_out(alarm_min_out), .alarm_hour_out(alarm_hour_out),
    .alarm_ring(alarm_ring), .sec_tick(sec_tick), .day_pulse(day_pulse)
  );

  typedef struct {
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       pm;
    logic [5:0] amin;
    logic [4:0] ahour;
    logic       ring, tick, day;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    logic       inc, dec, m12;
    logic [5:0] sec, min;
    logic [4:0] hour_disp;
    logic       pm;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int m, input int h, input int p,
                              input int am, input int ah, input int r, input int t, input int d);
    exp_t e;
    e.sec = 6'(s); e.min = 6'(m); e.hour = 5'(h); e.pm = 1'(p);
    e.amin = 6'(am); e.ahour = 5'(ah); e.ring = 1'(r); e.tick = 1'(t); e.day = 1'(d);
    return e;
  endfunction

  function automatic int disp12(input int h);
    if (h == 0 || h == 12) return 12;
    else if (h > 12)       return h - 12;
    else                   return h;
  endfunction

  function automatic void addv(input int sel, input int inc, input int dec, input int m12,
                               input int s, input int m, input int h, input int p);
    vec_t v;
    v.sel = 3'(sel); v.inc = 1'(inc); v.dec = 1'(dec); v.m12 = 1'(m12);
    v.sec = 6'(s); v.min = 6'(m); v.hour_disp = 5'(h); v.pm = 1'(p);
    vt.push_back(v);
  endfunction

  task automatic compare_out(input string tag, input exp_t e);
    chk({tag, ".sec"},   sec_out,        e.sec);
    chk({tag, ".min"},   min_out,        e.min);
    chk({tag, ".hour"},  hour_out,       e.hour);
    chk({tag, ".pm"},    pm_out,         e.pm);
    chk({tag, ".amin"},  alarm_min_out,  e.amin);
    chk({tag, ".ahour"}, alarm_hour_out, e.ahour);
    chk({tag, ".ring"},  alarm_ring,     e.ring);
    chk({tag, ".tick"},  sec_tick,       e.tick);
    chk({tag, ".day"},   day_pulse,      e.day);
  endtask

  // Inputs are already driven; queue the expectation, clock once, compare.
  task automatic cyc(input string tag, input exp_t e);
    exp_t g;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    compare_out(tag, g);
  endtask

  // mode 0: ack the ring, 1: let it time out, 2: async reset mid-ring.
  task automatic alarm_run(input int mode);
    int ring_ticks;
    int n;
    ring_ticks = 0;
    reset = 1'b0; select = 3'd0; increment = 1'b0; decrement = 1'b0;
    mode_12h = 1'b0; alarm_en = 1'b0; alarm_ack = 1'b0;
    cyc($sformatf("a%0d.rst", mode), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    select = 3'd4; increment = 1'b1;
    cyc($sformatf("a%0d.set1", mode), mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    select = 3'd1; increment = 1'b0;
    cyc($sformatf("a%0d.set2", mode), mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    select = 3'd0; alarm_en = 1'b1;
    for (int j = 1; j <= 130; j++) begin
      int rexp;
      n = (j + 1) / 2;
      rexp = (mode == 1) ? int'(j >= 119 && j <= 124) : int'(j == 119);
      cyc($sformatf("a%0d.c%0d", mode, j), mk(n % 60, n / 60, 0, 0, 1, 0, rexp, j % 2, 0));
      if (alarm_ring === 1'b1 && sec_tick === 1'b1) ring_ticks++;
      alarm_ack = (mode == 0 && j == 119);
      if (mode == 2 && j == 119) break;
    end
    if (mode == 1) chk("ring_len_ticks", ring_ticks, 3);
    if (mode == 2) begin
      #3;
      reset = 1'b0;
      #1;
      chk("async.ring", alarm_ring, 0);
      chk("async.sec",  sec_out,    0);
      chk("async.min",  min_out,    0);
      chk("async.amin", alarm_min_out, 0);
      chk("async.tick", sec_tick,   0);
      @(posedge clk);
      #1;
      chk("async.hold_tick", sec_tick,  0);
      chk("async.hold_day",  day_pulse, 0);
      chk("async.hold_ring", alarm_ring, 0);
      reset = 1'b1;
    end
    alarm_en = 1'b0; alarm_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    select = 3'd0; increment = 1'b0; decrement = 1'b0; mode_12h = 1'b0;
    alarm_en = 1'b0; alarm_ack = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // Reset held: everything zero, no pulses.
    for (int i = 0; i < 3; i++) cyc("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    // Free run from reset: one second every 2 clocks.
    for (int i = 1; i <= 120; i++)
      cyc($sformatf("run%0d", i), mk((i / 2) % 60, i / 120, 0, 0, 0, 0, 0, int'(i % 2 == 0), 0));

    // Setting vectors; time is 00:01:00 and frozen throughout.
    for (int k = 1; k <= 23; k++) begin
      addv(3, 1, 0, 0, 0, 1, k, int'(k >= 12));
      addv(3, 0, 0, 0, 0, 1, k, int'(k >= 12));
    end
    addv(3, 1, 0, 0, 0, 1, 0, 0);  addv(3, 0, 0, 0, 0, 1, 0, 0);
    addv(3, 0, 1, 0, 0, 1, 23, 1); addv(3, 0, 0, 0, 0, 1, 23, 1);
    addv(3, 1, 1, 0, 0, 1, 23, 1); addv(3, 0, 0, 0, 0, 1, 23, 1);
    addv(3, 1, 0, 0, 0, 1, 0, 0);  addv(3, 1, 0, 0, 0, 1, 0, 0);
    addv(3, 1, 0, 0, 0, 1, 0, 0);  addv(3, 0, 0, 0, 0, 1, 0, 0);
    addv(3, 0, 0, 1, 0, 1, 12, 0);
    for (int k = 1; k <= 13; k++) begin
      addv(3, 1, 0, 1, 0, 1, disp12(k), int'(k >= 12));
      addv(3, 0, 0, 1, 0, 1, disp12(k), int'(k >= 12));
    end
    for (int k = 14; k <= 23; k++) begin
      addv(3, 1, 0, 0, 0, 1, k, 1);
      addv(3, 0, 0, 0, 0, 1, k, 1);
    end
    addv(2, 0, 1, 0, 0, 0, 23, 1);   addv(2, 0, 0, 0, 0, 0, 23, 1);
    addv(2, 0, 1, 0, 0, 59, 23, 1);  addv(2, 0, 0, 0, 0, 59, 23, 1);
    addv(1, 0, 1, 0, 59, 59, 23, 1); addv(1, 0, 0, 0, 59, 59, 23, 1);
    addv(1, 1, 0, 0, 0, 59, 23, 1);  addv(1, 0, 0, 0, 0, 59, 23, 1);
    addv(1, 0, 1, 0, 59, 59, 23, 1); addv(1, 0, 0, 0, 59, 59, 23, 1);

    for (int i = 0; i < vt.size(); i++) begin
      select = vt[i].sel; increment = vt[i].inc; decrement = vt[i].dec; mode_12h = vt[i].m12;
      cyc($sformatf("vec%0d", i),
          mk(vt[i].sec, vt[i].min, vt[i].hour_disp, vt[i].pm, 0, 0, 0, 0, 0));
    end

    // Day rollover from 23:59:59.
    select = 3'd0; increment = 1'b0; decrement = 1'b0; mode_12h = 1'b0;
    cyc("roll1", mk(59, 59, 23, 1, 0, 0, 0, 0, 0));
    cyc("roll2", mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    cyc("roll3", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("roll4", mk(1, 0, 0, 0, 0, 0, 0, 1, 0));

    alarm_run(0);
    alarm_run(1);
    alarm_run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clock_alarm.md
Name: clock_alarm

Overview:
Parameterised time-of-day clock with an alarm. It is the successor to the basic hh:mm:ss clock and adds a configurable prescaler, increment/decrement field setting, runtime 12/24-hour display, alarm compare with ring/acknowledge, and a day-rollover pulse. It sits between the system clock and the display/segment drivers, and is set by debounced button levels.

Parameters:
TICKS_PER_SEC, 2, clk cycles per second (>=1; 1 = advance every cycle)
ALARM_LEN, 60, seconds alarm_ring stays high without ack (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
select  input  3  0=run, 1=set sec, 2=set min, 3=set hour, 4=set alarm min, 5=set alarm hour, 6/7=run
increment  input  1  level; rising edge steps selected field +1
decrement  input  1  level; rising edge steps selected field -1
mode_12h  input  1  1 = 12-hour display on hour_out
alarm_en  input  1  alarm armed
alarm_ack  input  1  level; clears alarm_ring
sec_out  output  6  seconds 0..59
min_out  output  6  minutes 0..59
hour_out  output  5  displayed hour: 0..23, or 1..12 when mode_12h
pm_out  output  1  internal hour >= 12 (valid in both modes)
alarm_min_out  output  6  alarm minute 0..59
alarm_hour_out  output  5  alarm hour 0..23 (always 24h)
alarm_ring  output  1  alarm active
sec_tick  output  1  one-cycle pulse on each seconds advance
day_pulse  output  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (reset=0, async): time 00:00:00, alarm 00:00, prescaler 0, edge registers 0, alarm_ring/sec_tick/day_pulse 0. With mode_12h=0, hour_out=0 and pm_out=0.
- Internal hour is always 24h. Display mapping is combinational: mode_12h=0 -> hour_out=hour. mode_12h=1 -> hour 0 and hour 12 display as 12; hours 13..23 display as hour-12; hours 1..11 unchanged.
- Prescaler counts 0..TICKS_PER_SEC-1. It advances only when select is in {0,4,5,6,7}.
- On the edge where the prescaler equals TICKS_PER_SEC-1: prescaler wraps to 0, seconds advance, and sec_tick=1 for that one cycle. Seconds carry into minutes; minutes carry into hours; hours wrap 23->0.
- day_pulse=1 for the cycle after the 23:59:59 -> 00:00:00 update.
- Time freeze: select 1..3 holds time and prescaler. An edit of sec/min/hour also clears the prescaler.
- Edge detection: increment and decrement are registered. A step occurs on the edge where input=1 and its registered copy=0. The new field value is visible the following cycle.
- Both edges detected in the same cycle: no change. Held levels produce exactly one step.
- Field steps wrap with no carry: sec/min 59<->0, hour and alarm hour 23<->0.
- Steps with select in {0,6,7} are ignored.
- Alarm match: alarm_en=1, hour==alarm hour, min==alarm min, sec==0, and a seconds advance occurred this cycle. On match, alarm_ring goes high on the same edge the time becomes hh:mm:00.
- Manual edits that land on the match time do not trigger the alarm.
- Ring duration counter: counts sec_tick pulses from the match. alarm_ring clears after ALARM_LEN ticks.
- alarm_ring also clears on the next edge with alarm_ack=1 or alarm_en=0. alarm_ack held high at match time suppresses the ring.
- Re-trigger during ring is not possible: a match requires sec==0 and ALARM_LEN<=60 by usage. If ALARM_LEN>60, a new match restarts the duration counter.
- Reset asserted mid-ring or mid-edit: immediate return to reset values, with no pulse glitches.

Test Plan:
- Reset: drive reset=0 for 1 cycle -> all outputs 0 and alarm 00:00; sec_tick/day_pulse never pulse during reset.
- Run counting (TICKS_PER_SEC=2, select=0): 120 clk cycles from reset -> 00:01:00, with sec_tick pulsing every 2nd cycle. Preload 23:59:59 via setting, then return to select=0 -> after 2 cycles 00:00:00 and day_pulse high exactly 1 cycle.
- Setting: select=3 with 23 increment pulses -> hour 23, min/sec unchanged. One more pulse -> hour 0. Then a decrement -> 23. increment and decrement raised together -> no change. Time frozen throughout.
- 12h mode: hour 0 with mode_12h=1 -> hour_out=12, pm_out=0. hour 13 -> hour_out=1, pm_out=1. hour 12 -> hour_out=12, pm_out=1.
- Alarm: alarm set to 00:01, alarm_en=1, start at 00:00:00 -> alarm_ring rises on the edge time becomes 00:01:00. Pulse alarm_ack -> ring low next cycle and stays low. Repeat without ack and ALARM_LEN=3 -> ring lasts exactly 3 sec_tick pulses.
- Async reset mid-ring: pull reset low between clock edges while alarm_ring=1 -> ring and time go to 0 immediately, without waiting for clk.
